seg_scan_mmio: RTL and testbench
================================

SEG_SCAN_MMIO -- requirements
Module: seg_scan_mmio

Interface
REQ-001 Parameter DIGITS, 4, number of seven-segment digits; SHALL be a multiple of 4 in the range 4..16.
REQ-002 Parameter NBTN, 2, number of push buttons; range 1..16.
REQ-003 Parameter SCAN_DIV, 50000, clk cycles per digit-scan tick; minimum 2.
REQ-004 Parameter DEB_CYCLES, 250000, clk cycles a button level must stay stable before it is accepted; minimum 2.
REQ-005 clk  in  1  single clock; all logic SHALL be on the rising edge.
REQ-006 res  in  1  reset, synchronous, active-high.
REQ-007 sel  in  1  bus select.
REQ-008 ld  in  1  1 = read, 0 = write, qualified by sel.
REQ-009 addr  in  12  register word address.
REQ-010 wdata  in  16  write data.
REQ-011 rdata  out  16  registered read data.
REQ-012 btn_n  in  NBTN  raw buttons, active-low, asynchronous.
REQ-013 dig  out  DIGITS  digit enables, active-low, one-hot.
REQ-014 seg  out  8  segments, active-low; seg[7] = decimal point, seg[6:0] = g..a.

Function
REQ-015 Register map: 0x000 BTN (RO), 0x001 EVT (W1C), 0x002 CTRL, 0x003 DP, 0x004 .. 0x004+DIGITS/4-1 VAL words (4 nibbles each, least-significant digit in word 0 bits [3:0]).
REQ-016 CTRL bit0 EN enables the display; CTRL bit1 LZB enables leading-zero blanking; other bits SHALL read 0.
REQ-017 DP bit i lights the decimal point of digit i; bits at or above DIGITS SHALL read 0.
REQ-018 Read: on a cycle with sel=1 and ld=1, rdata SHALL present the addressed register on the next cycle (1-cycle latency).
REQ-019 rdata SHALL be 0 on the cycle after any cycle with sel=0, with a write, or with an unmapped read address.
REQ-020 Write: sel=1 and ld=0 SHALL update the addressed register at that edge; writes to BTN or to unmapped addresses SHALL be ignored.
REQ-021 Each btn_n bit SHALL pass a 2-flop synchroniser and then be inverted.
REQ-022 Each button SHALL have a debounce counter that restarts on any change of the synchronised level. The debounced state SHALL update when the level has been stable for DEB_CYCLES cycles.
REQ-023 BTN[NBTN-1:0] SHALL read the debounced pressed state (1 = pressed).
REQ-024 A debounced 0->1 transition SHALL set EVT bit i; the bit SHALL be cleared by writing 1 to it.
REQ-025 If a press event and a W1C of the same EVT bit occur in the same cycle, the bit SHALL end up set.
REQ-026 A prescaler SHALL count 0..SCAN_DIV-1 and generate a one-cycle tick at terminal count.
REQ-027 On each tick the scan index SHALL advance by 1 modulo DIGITS; the advance from DIGITS-1 to 0 is the wrap.
REQ-028 At each wrap, the VAL and DP registers SHALL be copied into a display snapshot, so the displayed frame never tears. Digits SHALL be driven only from the snapshot.
REQ-029 dig and seg SHALL be registered and SHALL update on the tick edge. dig SHALL drive index k low and all other bits high.
REQ-030 seg[6:0] SHALL be the active-low hex encoding of the snapshot nibble: 0..F = 3f,06,5b,4f,66,6d,7d,07,7f,6f,77,7c,39,5e,79,71, each inverted.
REQ-031 seg[7] SHALL be the inverse of the snapshot DP bit for the current digit.
REQ-032 With LZB=1, digit i (i>0) SHALL drive seg = 8'hFF when its nibble and all higher nibbles are 0; digit 0 is never blanked.
REQ-033 With EN=0, dig SHALL be all ones and seg SHALL be 8'hFF; the prescaler and scan index SHALL keep running.

Reset
REQ-034 On res=1 at a clock edge the following SHALL be cleared:
- CTRL, DP, VAL, snapshot, EVT, debounced state and debounce counters, synchronisers to released, prescaler and scan index to 0.
- outputs: rdata=0, dig all ones, seg=8'hFF.
REQ-035 A reset asserted mid-scan or mid-debounce SHALL take effect in one cycle and SHALL generate no EVT bit.

Structure
REQ-036 A shared package SHALL hold the register address constants, the CTRL bit indices and the 16-entry seven-segment encoding table.
REQ-037 Debouncing SHALL be a sub-module btn_debounce, instantiated NBTN times; scan and bus logic SHALL stay in seg_scan_mmio.

Verification (bench parameters: DIGITS=8, SCAN_DIV=4, DEB_CYCLES=8)
REQ-038 Reset scenario: after res, read CTRL -> rdata=0x0000 one cycle later; dig=8'hFF and seg=8'hFF.
REQ-039 Display scenario:
- stimulus: write VAL0=0x1234, VAL1=0x0000, CTRL=0x0001, then wait for a wrap.
- required: digit 0 shows ~7'h66 ("4") and digit 3 shows ~7'h06 ("1"); each digit holds 4 cycles.
REQ-040 Blanking scenario: same values with CTRL=0x0003 -> digits 4..7 seg=8'hFF and digits 0..3 unchanged; DP=0x01 -> seg[7]=0 on digit 0 only.
REQ-041 Debounce scenario:
- stimulus: btn_n[0] glitches low for 5 cycles.
- required: BTN=0 and EVT=0.
- stimulus: btn_n[0] held low for 20 cycles.
- required: BTN=0x0001 and EVT=0x0001.
REQ-042 W1C scenario: write EVT=0x0001 in the same cycle as a new debounced press -> EVT reads 0x0001; a later W1C with no press -> EVT reads 0x0000.
REQ-043 Snapshot scenario: write VAL0=0xABCD mid-frame -> the displayed digits change only after the next wrap; read of 0x3FF -> rdata=0.

Source files
------------

// File: rtl/seg_scan_mmio_pkg.sv
// Shared constants for the seven-segment scanner: register map, CTRL bits and
// the hex-to-segment table.
package seg_scan_mmio_pkg;

  localparam logic [11:0] AddrBtn  = 12'h000;
  localparam logic [11:0] AddrEvt  = 12'h001;
  localparam logic [11:0] AddrCtrl = 12'h002;
  localparam logic [11:0] AddrDp   = 12'h003;
  localparam logic [11:0] AddrVal0 = 12'h004;

  localparam int unsigned CtrlEn  = 0;
  localparam int unsigned CtrlLzb = 1;

  // Active-high segments g..a, entry 15 first.
  localparam logic [15:0][6:0] SegTable = {
    7'h71, 7'h79, 7'h5e, 7'h39, 7'h7c, 7'h77, 7'h6f, 7'h7f,
    7'h07, 7'h7d, 7'h6d, 7'h66, 7'h4f, 7'h5b, 7'h06, 7'h3f
  };

  function automatic logic [7:0] seg_drive(logic [3:0] nib, logic dp, logic blank);
    if (blank) return 8'hFF;
    return {~dp, ~SegTable[nib]};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push button: 2-flop synchroniser, inversion to pressed level, and a
// stability counter that restarts whenever the level returns to the debounced state.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic res,
  input  logic btn_n_i,
  output logic pressed_o,
  output logic rise_o
);

  localparam int unsigned CntW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  logic            sync1_q, sync2_q;
  logic            state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            lvl, done;

  assign lvl  = ~sync2_q;
  assign done = (cnt_q == CntW'(DEB_CYCLES - 1));

  always_comb begin
    cnt_d   = '0;
    state_d = state_q;
    if (lvl != state_q) begin
      if (done) state_d = lvl;
      else      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pressed_o = state_q;
  assign rise_o    = done & lvl & ~state_q;

endmodule

// File: rtl/seg_scan_mmio.sv
// Memory-mapped multiplexed seven-segment display driver with debounced buttons.
// Digits are driven from a snapshot refreshed once per frame so a frame never tears.
import seg_scan_mmio_pkg::*;

module seg_scan_mmio #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned NBTN       = 2,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DEB_CYCLES = 250000
) (
  input  logic              clk,
  input  logic              res,
  input  logic              sel,
  input  logic              ld,
  input  logic [11:0]       addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  input  logic [NBTN-1:0]   btn_n,
  output logic [DIGITS-1:0] dig,
  output logic [7:0]        seg
);

  localparam int unsigned NWords = DIGITS / 4;
  localparam int unsigned IdxW   = $clog2(DIGITS);
  localparam int unsigned PreW   = $clog2(SCAN_DIV);

  logic                rd, wr;
  logic [1:0]          ctrl_q, ctrl_d;
  logic [DIGITS-1:0]   dp_q, dp_d, snap_dp_q, snap_dp_d;
  logic [4*DIGITS-1:0] val_q, val_d, snap_val_q, snap_val_d;
  logic [NBTN-1:0]     evt_q, evt_d, pressed, rise;
  logic [15:0]         rdata_q, rdata_d;
  logic [PreW-1:0]     pre_q, pre_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0]   dig_q, dig_d, lz;
  logic [7:0]          seg_q, seg_d;
  logic [3:0]          nib;
  logic                tick, wrap, blank;

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk       (clk),
      .res       (res),
      .btn_n_i   (btn_n[i]),
      .pressed_o (pressed[i]),
      .rise_o    (rise[i])
    );
  end

  assign rd = sel & ld;
  assign wr = sel & ~ld;

  always_comb begin
    ctrl_d  = ctrl_q;
    dp_d    = dp_q;
    val_d   = val_q;
    evt_d   = evt_q;
    rdata_d = '0;
    if (wr) begin
      if (addr == AddrEvt)  evt_d  = evt_q & ~wdata[NBTN-1:0];
      if (addr == AddrCtrl) ctrl_d = wdata[1:0];
      if (addr == AddrDp)   dp_d   = wdata[DIGITS-1:0];
      for (int unsigned w = 0; w < NWords; w++) begin
        if (addr == AddrVal0 + 12'(w)) val_d[16*w +: 16] = wdata;
      end
    end
    // A press in the same cycle as its W1C wins.
    evt_d = evt_d | rise;
    if (rd) begin
      if (addr == AddrBtn)  rdata_d = 16'(pressed);
      if (addr == AddrEvt)  rdata_d = 16'(evt_q);
      if (addr == AddrCtrl) rdata_d = {14'b0, ctrl_q};
      if (addr == AddrDp)   rdata_d = 16'(dp_q);
      for (int unsigned w = 0; w < NWords; w++) begin
        if (addr == AddrVal0 + 12'(w)) rdata_d = val_q[16*w +: 16];
      end
    end
  end

  always_comb begin
    tick       = (pre_q == PreW'(SCAN_DIV - 1));
    wrap       = tick && (idx_q == IdxW'(DIGITS - 1));
    pre_d      = tick ? '0 : pre_q + 1'b1;
    idx_d      = idx_q;
    snap_val_d = snap_val_q;
    snap_dp_d  = snap_dp_q;
    if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;
    if (wrap) begin
      snap_val_d = val_q;
      snap_dp_d  = dp_q;
    end
  end

  // lz[i]: nibble i and every nibble above it are zero.
  always_comb begin
    lz = '0;
    lz[DIGITS-1] = (snap_val_d[4*DIGITS-4 +: 4] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      lz[i] = (snap_val_d[4*i +: 4] == 4'h0) && lz[i+1];
    end
  end

  always_comb begin
    nib   = snap_val_d[{idx_d, 2'b00} +: 4];
    blank = ctrl_q[CtrlLzb] && (idx_d != '0) && lz[idx_d];
    dig_d = dig_q;
    seg_d = seg_q;
    if (!ctrl_q[CtrlEn]) begin
      dig_d = '1;
      seg_d = 8'hFF;
    end else if (tick) begin
      dig_d = ~(DIGITS'(1) << idx_d);
      seg_d = seg_drive(nib, snap_dp_d[idx_d], blank);
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      ctrl_q     <= '0;
      dp_q       <= '0;
      val_q      <= '0;
      snap_dp_q  <= '0;
      snap_val_q <= '0;
      evt_q      <= '0;
      rdata_q    <= '0;
      pre_q      <= '0;
      idx_q      <= '0;
      dig_q      <= '1;
      seg_q      <= 8'hFF;
    end else begin
      ctrl_q     <= ctrl_d;
      dp_q       <= dp_d;
      val_q      <= val_d;
      snap_dp_q  <= snap_dp_d;
      snap_val_q <= snap_val_d;
      evt_q      <= evt_d;
      rdata_q    <= rdata_d;
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      dig_q      <= dig_d;
      seg_q      <= seg_d;
    end
  end

  assign rdata = rdata_q;
  assign dig   = dig_q;
  assign seg   = seg_q;

endmodule

// File: tb/tb_seg_scan_mmio.sv
// Directed bench for seg_scan_mmio with DIGITS=8, SCAN_DIV=4, DEB_CYCLES=8.
module tb_seg_scan_mmio;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        sel = 1'b0;
  logic        ld = 1'b1;
  logic [11:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic [1:0]  btn_n = 2'b11;
  logic [7:0]  dig;
  logic [7:0]  seg;

  int total = 0;
  int bad = 0;
  logic [15:0] rd_val;

  seg_scan_mmio #(
    .DIGITS     (8),
    .NBTN       (2),
    .SCAN_DIV   (4),
    .DEB_CYCLES (8)
  ) dut (
    .clk   (clk),
    .res   (res),
    .sel   (sel),
    .ld    (ld),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .btn_n (btn_n),
    .dig   (dig),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [11:0] a, input logic [15:0] d);
    sel = 1'b1; ld = 1'b0; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; ld = 1'b1;
  endtask

  task automatic do_read(input logic [11:0] a, output logic [15:0] d);
    sel = 1'b1; ld = 1'b1; addr = a;
    @(negedge clk);
    d = rdata;
    sel = 1'b0;
  endtask

  // Leave the current digit-0 period, then wait for the next frame start.
  task automatic wait_frame();
    int n = 0;
    while (dig === 8'hFE && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (dig !== 8'hFE && n < 200) begin @(negedge clk); n++; end
    chk("frame_sync", 16'(dig), 16'h00FE);
  endtask

  task automatic check_frame(input string tag, input logic [7:0][7:0] exp);
    logic [7:0] want_dig;
    wait_frame();
    for (int k = 0; k < 8; k++) begin
      want_dig = 8'h01 << k;
      want_dig = ~want_dig;
      chk($sformatf("%s dig%0d", tag, k), 16'(dig), 16'(want_dig));
      chk($sformatf("%s seg%0d", tag, k), 16'(seg), 16'(exp[k]));
      repeat (3) @(negedge clk);
      chk($sformatf("%s hold%0d", tag, k), 16'(dig), 16'(want_dig));
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    chk("rst_dig", 16'(dig), 16'h00FF);
    chk("rst_seg", 16'(seg), 16'h00FF);
    res = 1'b0;
    do_read(12'h002, rd_val); chk("rst_ctrl", rd_val, 16'h0000);
    do_read(12'h001, rd_val); chk("rst_evt", rd_val, 16'h0000);

    // Display: 0x1234 in VAL0, display enabled
    do_write(12'h004, 16'h1234);
    chk("rdata_after_wr", rdata, 16'h0000);
    do_write(12'h005, 16'h0000);
    do_write(12'h002, 16'h0001);
    do_read(12'h004, rd_val); chk("rd_val0", rd_val, 16'h1234);
    @(negedge clk);
    chk("rdata_idle", rdata, 16'h0000);
    // digit 7 .. digit 0
    check_frame("disp", {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99});

    // Leading-zero blanking, then decimal point on digit 0
    do_write(12'h002, 16'h0003);
    do_read(12'h002, rd_val); chk("rd_ctrl", rd_val, 16'h0003);
    check_frame("lzb", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hA4, 8'hB0, 8'h99});
    do_write(12'h003, 16'hFF01);
    do_read(12'h003, rd_val); chk("rd_dp", rd_val, 16'h0001);
    check_frame("dp", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hA4, 8'hB0, 8'h19});

    // Debounce: short glitch ignored
    btn_n = 2'b10;
    repeat (5) @(negedge clk);
    btn_n = 2'b11;
    repeat (20) @(negedge clk);
    do_read(12'h000, rd_val); chk("glitch_btn", rd_val, 16'h0000);
    do_read(12'h001, rd_val); chk("glitch_evt", rd_val, 16'h0000);
    // Debounce: long press accepted
    btn_n = 2'b10;
    repeat (20) @(negedge clk);
    do_read(12'h000, rd_val); chk("press_btn", rd_val, 16'h0001);
    do_read(12'h001, rd_val); chk("press_evt", rd_val, 16'h0001);
    // Release gives no event; W1C clears
    btn_n = 2'b11;
    repeat (20) @(negedge clk);
    do_read(12'h000, rd_val); chk("rel_btn", rd_val, 16'h0000);
    do_read(12'h001, rd_val); chk("rel_evt", rd_val, 16'h0001);
    do_write(12'h001, 16'h0001);
    do_read(12'h001, rd_val); chk("w1c_clr", rd_val, 16'h0000);

    // W1C coinciding with a press: 2 sync edges + 8 stable cycles puts the
    // debounced rise on the 10th edge after btn_n falls.
    btn_n = 2'b10;
    repeat (9) @(negedge clk);
    do_write(12'h001, 16'h0001);
    do_read(12'h001, rd_val); chk("w1c_race_evt", rd_val, 16'h0001);
    do_read(12'h000, rd_val); chk("w1c_race_btn", rd_val, 16'h0001);
    do_write(12'h001, 16'h0001);
    do_read(12'h001, rd_val); chk("w1c_later", rd_val, 16'h0000);
    btn_n = 2'b11;

    // Snapshot: a mid-frame write only shows after the next wrap
    wait_frame();
    repeat (8) @(negedge clk);
    chk("snap_dig2", 16'(dig), 16'h00FB);
    chk("snap_seg2", 16'(seg), 16'h00A4);
    do_write(12'h004, 16'hABCD);
    repeat (3) @(negedge clk);
    chk("snap_dig3", 16'(dig), 16'h00F7);
    chk("snap_seg3", 16'(seg), 16'h00F9);
    check_frame("snap", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h88, 8'h83, 8'hC6, 8'h21});
    do_read(12'h004, rd_val); chk("rd_abcd", rd_val, 16'hABCD);
    do_read(12'h3FF, rd_val); chk("rd_unmapped", rd_val, 16'h0000);

    // Reset in the middle of a scan
    repeat (5) @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    chk("mid_rst_dig", 16'(dig), 16'h00FF);
    chk("mid_rst_seg", 16'(seg), 16'h00FF);
    do_read(12'h002, rd_val); chk("mid_rst_ctrl", rd_val, 16'h0000);
    do_read(12'h004, rd_val); chk("mid_rst_val0", rd_val, 16'h0000);
    repeat (40) @(negedge clk);
    chk("mid_rst_dark", 16'(dig), 16'h00FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
